loadarch_injector: RTL and testbench

//  Synthesizable multi-hart architectural-state loader. Consumes a stream of (hart, kind, index, data) records,

---
 rtl/loadarch_injector_pkg.sv | 40 ++++
 rtl/loadarch_injector_if.sv | 38 +++
 rtl/loadarch_injector_release_seq.sv | 77 +++++++
 rtl/loadarch_injector.sv | 198 +++++++++++++++++++
 tb/tb_loadarch_injector.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loadarch_injector_pkg.sv
// Shared types and widths for the architectural-state loader.
package loadarch_injector_pkg;

  localparam int unsigned KindW  = 2;
  localparam int unsigned IdxW   = 12;
  localparam int unsigned ErrW   = 3;
  localparam int unsigned CountW = 16;

  typedef enum logic [KindW-1:0] {
    KindXpr = 2'd0,
    KindFpr = 2'd1,
    KindCsr = 2'd2,
    KindPc  = 2'd3
  } rec_kind_e;

  typedef enum logic [ErrW-1:0] {
    ErrNone       = 3'd0,
    ErrBadHart    = 3'd1,
    ErrBadIdx     = 3'd2,
    ErrAckTimeout = 3'd3,
    ErrMissingPc  = 3'd4,
    ErrStartBusy  = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StAccept,
    StWrite,
    StCheck,
    StRelease,
    StDone,
    StError
  } state_e;

  function automatic int unsigned hart_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/loadarch_injector_if.sv
// Record stream in from the loadarch source, restore-port writes out to the harts.
interface loadarch_injector_if #(
  parameter int unsigned NumHarts = 2,
  parameter int unsigned Xlen     = 64
);
  import loadarch_injector_pkg::*;

  localparam int unsigned HartW = hart_width(NumHarts);

  logic                rec_valid;
  logic                rec_ready;
  logic [HartW-1:0]    rec_hart;
  rec_kind_e           rec_kind;
  logic [IdxW-1:0]     rec_idx;
  logic [Xlen-1:0]     rec_data;
  logic                rec_last;

  logic [NumHarts-1:0] wr_valid;
  rec_kind_e           wr_kind;
  logic [IdxW-1:0]     wr_idx;
  logic [Xlen-1:0]     wr_data;
  logic [NumHarts-1:0] wr_ack;

  modport master (
    output rec_valid, rec_hart, rec_kind, rec_idx, rec_data, rec_last,
    input  rec_ready,
    input  wr_valid, wr_kind, wr_idx, wr_data,
    output wr_ack
  );

  modport slave (
    input  rec_valid, rec_hart, rec_kind, rec_idx, rec_data, rec_last,
    output rec_ready,
    output wr_valid, wr_kind, wr_idx, wr_data,
    input  wr_ack
  );

endinterface

// File: rtl/loadarch_injector_release_seq.sv
// Staggered per-hart reset release: hart 0 on start, then one more hart every ReleaseGap cycles.
module loadarch_injector_release_seq #(
  parameter int unsigned NumHarts   = 2,
  parameter int unsigned ReleaseGap = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_i,
  input  logic                hold_i,
  output logic [NumHarts-1:0] hart_reset_n_o,
  output logic                done_o,
  output logic                last_o
);
  localparam int unsigned GapW = (ReleaseGap <= 1) ? 1 : $clog2(ReleaseGap);
  localparam int unsigned CntW = $clog2(NumHarts + 1);

  logic [NumHarts-1:0] rst_n_q, rst_n_d;
  logic [CntW-1:0]     rel_q, rel_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic                active_q, active_d;
  logic                done_q, done_d;

  // Every hart is out of reset; done follows on the next edge.
  assign last_o = active_q && (32'(rel_q) == NumHarts);

  always_comb begin
    rst_n_d  = rst_n_q;
    rel_d    = rel_q;
    gap_d    = gap_q;
    active_d = active_q;
    done_d   = done_q;
    if (hold_i) begin
      rst_n_d  = '0;
      rel_d    = '0;
      gap_d    = '0;
      active_d = 1'b0;
      done_d   = 1'b0;
    end else if (start_i) begin
      rst_n_d  = NumHarts'(1);
      rel_d    = CntW'(1);
      gap_d    = '0;
      active_d = 1'b1;
      done_d   = 1'b0;
    end else if (active_q) begin
      if (last_o) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else if (32'(gap_q) == ReleaseGap - 1) begin
        rst_n_d[rel_q] = 1'b1;
        rel_d          = rel_q + CntW'(1);
        gap_d          = '0;
      end else begin
        gap_d = gap_q + GapW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_n_q  <= '1;
      rel_q    <= '0;
      gap_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rst_n_q  <= rst_n_d;
      rel_q    <= rel_d;
      gap_q    <= gap_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign hart_reset_n_o = rst_n_q;
  assign done_o         = done_q;

endmodule

// File: rtl/loadarch_injector.sv
// Multi-hart architectural-state loader: writes records into held harts, then releases them.
module loadarch_injector
  import loadarch_injector_pkg::*;
#(
  parameter int unsigned NumHarts   = 2,
  parameter int unsigned Xlen       = 64,
  parameter int unsigned NumXpr     = 32,
  parameter int unsigned NumFpr     = 32,
  parameter int unsigned NumCsr     = 4096,
  parameter int unsigned AckTimeout = 64,
  parameter int unsigned ReleaseGap = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_i,
  loadarch_injector_if.slave  bus,
  output logic [NumHarts-1:0] hart_reset_n_o,
  output logic                done_o,
  output logic                error_o,
  output logic [ErrW-1:0]     err_code_o,
  output logic [CountW-1:0]   rec_count_o
);
  localparam int unsigned HartW = hart_width(NumHarts);
  localparam int unsigned TmoW  = $clog2(AckTimeout + 1);

  state_e              state_q, state_d;
  logic [HartW-1:0]    hart_q, hart_d;
  rec_kind_e           kind_q, kind_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [Xlen-1:0]     data_q, data_d;
  logic                last_q, last_d;
  logic [NumHarts-1:0] pc_seen_q, pc_seen_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [CountW-1:0]   count_q, count_d;
  logic                error_q, error_d;
  err_code_e           err_q, err_d;

  logic      accept, hart_ok, idx_ok, busy, raise, rel_start, rel_hold, rel_last;
  err_code_e code;

  assign accept = bus.rec_valid && bus.rec_ready;
  assign busy   = state_q inside {StHold, StAccept, StWrite, StCheck, StRelease};

  always_comb begin
    hart_ok = 32'(bus.rec_hart) < NumHarts;
    unique case (bus.rec_kind)
      KindXpr: idx_ok = 32'(bus.rec_idx) < NumXpr;
      KindFpr: idx_ok = 32'(bus.rec_idx) < NumFpr;
      KindCsr: idx_ok = 32'(bus.rec_idx) < NumCsr;
      default: idx_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hart_d    = hart_q;
    kind_d    = kind_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    pc_seen_d = pc_seen_q;
    tmo_d     = tmo_q;
    count_d   = count_q;
    error_d   = error_q;
    err_d     = err_q;
    raise     = 1'b0;
    code      = ErrNone;
    rel_start = 1'b0;
    rel_hold  = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d   = StHold;
          pc_seen_d = '0;
          count_d   = '0;
          error_d   = 1'b0;
          err_d     = ErrNone;
          rel_hold  = 1'b1;
        end
      end
      StHold: state_d = StAccept;
      StAccept: begin
        if (accept) begin
          hart_d = bus.rec_hart;
          kind_d = bus.rec_kind;
          idx_d  = bus.rec_idx;
          data_d = bus.rec_data;
          last_d = bus.rec_last;
          tmo_d  = '0;
          if (!hart_ok) begin
            raise = 1'b1;
            code  = ErrBadHart;
          end else if (!idx_ok) begin
            raise = 1'b1;
            code  = ErrBadIdx;
          end else if (bus.rec_kind == KindXpr && bus.rec_idx == '0) begin
            // x0 is hardwired; swallow the record without a write.
            if (bus.rec_last) state_d = StCheck;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (bus.wr_ack[hart_q]) begin
          if (count_q != '1) count_d = count_q + CountW'(1);
          if (kind_q == KindPc) pc_seen_d[hart_q] = 1'b1;
          state_d = last_q ? StCheck : StAccept;
        end else if (32'(tmo_q) == AckTimeout - 1) begin
          raise = 1'b1;
          code  = ErrAckTimeout;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StCheck: begin
        if (pc_seen_q != '1) begin
          raise = 1'b1;
          code  = ErrMissingPc;
        end else begin
          state_d   = StRelease;
          rel_start = 1'b1;
        end
      end
      StRelease: if (rel_last) state_d = StDone;
      default: ;
    endcase

    if (busy && start_i) begin
      raise = 1'b1;
      code  = ErrStartBusy;
    end
    // Any error puts every hart back into reset, even mid-release.
    if (raise) begin
      state_d   = StError;
      error_d   = 1'b1;
      err_d     = code;
      rel_start = 1'b0;
      rel_hold  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      hart_q    <= '0;
      kind_q    <= KindXpr;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      pc_seen_q <= '0;
      tmo_q     <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      err_q     <= ErrNone;
    end else begin
      state_q   <= state_d;
      hart_q    <= hart_d;
      kind_q    <= kind_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      pc_seen_q <= pc_seen_d;
      tmo_q     <= tmo_d;
      count_q   <= count_d;
      error_q   <= error_d;
      err_q     <= err_d;
    end
  end

  loadarch_injector_release_seq #(
    .NumHarts   (NumHarts),
    .ReleaseGap (ReleaseGap)
  ) u_release_seq (
    .clock          (clock),
    .reset          (reset),
    .start_i        (rel_start),
    .hold_i         (rel_hold),
    .hart_reset_n_o (hart_reset_n_o),
    .done_o         (done_o),
    .last_o         (rel_last)
  );

  always_comb begin
    bus.wr_valid = '0;
    if (state_q == StWrite) bus.wr_valid[hart_q] = 1'b1;
  end

  assign bus.rec_ready = (state_q == StAccept);
  assign bus.wr_kind   = kind_q;
  assign bus.wr_idx    = idx_q;
  assign bus.wr_data   = data_q;
  assign error_o       = error_q;
  assign err_code_o    = err_q;
  assign rec_count_o   = count_q;

endmodule

// File: tb/tb_loadarch_injector.sv
// Randomized scoreboard bench for loadarch_injector with a record-level reference model.
module tb_loadarch_injector;
  import loadarch_injector_pkg::*;

  localparam int NH  = 3;
  localparam int GAP = 4;
  localparam int TMO = 64;

  typedef struct {
    logic [1:0]  hart;
    logic [1:0]  kind;
    logic [11:0] idx;
    logic [63:0] data;
    logic        last;
  } rec_t;

  typedef struct {
    logic [1:0]  hart;
    logic [1:0]  kind;
    logic [11:0] idx;
    logic [63:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [NH-1:0] hart_reset_n;
  logic          done, error;
  logic [2:0]    err_code;
  logic [15:0]   rec_count;

  always #5 clock = ~clock;

  loadarch_injector_if #(.NumHarts(NH), .Xlen(64)) bus ();

  loadarch_injector #(
    .NumHarts   (NH),
    .Xlen       (64),
    .NumXpr     (32),
    .NumFpr     (32),
    .NumCsr     (4096),
    .AckTimeout (TMO),
    .ReleaseGap (GAP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start_i        (start),
    .bus            (bus),
    .hart_reset_n_o (hart_reset_n),
    .done_o         (done),
    .error_o        (error),
    .err_code_o     (err_code),
    .rec_count_o    (rec_count)
  );

  int total = 0;
  int bad   = 0;
  wr_t exp_q[$];
  wr_t cur;
  logic withhold = 1'b0;
  int cyc = 0;
  int rise[NH];
  int done_rise = 0;
  logic [NH-1:0] prev_rn = '1;
  logic prev_done = 1'b0;
  logic prev_v = 1'b0;
  int waited = 0;
  int ack_delay = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int h, input int k, input int idx, input logic [63:0] d,
                              input bit last);
    rec_t r;
    r.hart = 2'(h);
    r.kind = 2'(k);
    r.idx  = 12'(idx);
    r.data = d;
    r.last = last;
    return r;
  endfunction

  // Monitor and ack responder: checks each new write request against the scoreboard.
  initial begin
    logic [NH-1:0] oh;
    logic [NH-1:0] ack;
    bus.wr_ack = '0;
    forever begin
      @(negedge clock);
      cyc++;
      for (int h = 0; h < NH; h++) if (hart_reset_n[h] && !prev_rn[h]) rise[h] = cyc;
      if (done && !prev_done) done_rise = cyc;
      prev_rn   = hart_reset_n;
      prev_done = done;
      if (bus.wr_valid != '0 && !prev_v) begin
        waited    = 0;
        ack_delay = $urandom_range(0, 2);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected write: wr_valid=%0h idx=%0h", bus.wr_valid, bus.wr_idx);
        end else begin
          cur = exp_q.pop_front();
          oh = '0;
          oh[cur.hart] = 1'b1;
          chk("wr_valid", 64'(bus.wr_valid), 64'(oh));
          chk("wr_kind", 64'(bus.wr_kind), 64'(cur.kind));
          chk("wr_idx", 64'(bus.wr_idx), 64'(cur.idx));
          chk("wr_data", bus.wr_data, cur.data);
        end
      end
      prev_v = (bus.wr_valid != '0);
      ack = '0;
      if (bus.wr_valid != '0 && !withhold && waited >= ack_delay) begin
        ack = bus.wr_valid;
        chk("wr_data at ack", bus.wr_data, cur.data);
      end
      ack = ack | (NH'($urandom_range(0, 7)) & ~bus.wr_valid);
      bus.wr_ack = ack;
      waited++;
    end
  end

  // Reference model: walks records, queues expected writes, predicts final status.
  task automatic model(input rec_t recs[$], input int hold_at, output int n_used,
                       output int code, output int cnt);
    logic [NH-1:0] pc;
    int lim;
    pc = '0;
    code = 0;
    cnt = 0;
    n_used = recs.size();
    for (int i = 0; i < recs.size(); i++) begin
      lim = (recs[i].kind < 2) ? 32 : 4096;
      if (int'(recs[i].hart) >= NH) begin code = 1; n_used = i + 1; return; end
      if (int'(recs[i].idx) >= lim) begin code = 2; n_used = i + 1; return; end
      if (!(recs[i].kind == 0 && recs[i].idx == 0)) begin
        exp_q.push_back('{recs[i].hart, recs[i].kind, recs[i].idx, recs[i].data});
        if (i == hold_at) begin code = 3; n_used = i + 1; return; end
        cnt++;
        if (recs[i].kind == 3) pc[recs[i].hart] = 1'b1;
      end
      if (recs[i].last) begin
        n_used = i + 1;
        if (pc != '1) code = 4;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drive_rec(input rec_t r, input logic hold);
    int guard = 0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    bus.rec_valid = 1'b1;
    bus.rec_hart  = r.hart;
    bus.rec_kind  = rec_kind_e'(r.kind);
    bus.rec_idx   = r.idx;
    bus.rec_data  = r.data;
    bus.rec_last  = r.last;
    while (!bus.rec_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL rec_ready wait: got timeout want ready");
    end else begin
      withhold = hold;
      @(negedge clock);
    end
    bus.rec_valid = 1'b0;
  endtask

  task automatic run_seq(input string tag, input rec_t recs[$], input int hold_at);
    int n_used, code, cnt;
    int guard = 0;
    model(recs, hold_at, n_used, code, cnt);
    pulse_start();
    chk({tag, " hold reset_n"}, 64'(hart_reset_n), 64'(0));
    chk({tag, " hold error"}, 64'(error), 64'(0));
    chk({tag, " hold ready"}, 64'(bus.rec_ready), 64'(0));
    for (int i = 0; i < n_used; i++) drive_rec(recs[i], i == hold_at);
    while (!done && !error && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    chk({tag, " finished"}, 64'(guard < 400), 64'(1));
    chk({tag, " err_code"}, 64'(err_code), 64'(code));
    chk({tag, " error"}, 64'(error), 64'(code != 0));
    chk({tag, " done"}, 64'(done), 64'(code == 0));
    chk({tag, " rec_count"}, 64'(rec_count), 64'(cnt));
    chk({tag, " reset_n"}, 64'(hart_reset_n), (code == 0) ? 64'((1 << NH) - 1) : 64'(0));
    if (code == 0) begin
      for (int h = 1; h < NH; h++) chk({tag, " release gap"}, 64'(rise[h] - rise[0]), 64'(h * GAP));
      chk({tag, " done delay"}, 64'(done_rise - rise[0]), 64'((NH - 1) * GAP + 1));
    end
    chk({tag, " scoreboard empty"}, 64'(exp_q.size()), 64'(0));
    withhold = 1'b0;
  endtask

  task automatic rand_seq(input int s);
    rec_t q[$];
    int n = $urandom_range(1, 6);
    int hold_at = -1;
    for (int i = 0; i < n; i++) begin
      int k = $urandom_range(0, 3);
      int h = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NH - 1);
      int idx = $urandom_range(0, 4095);
      if (k < 2) idx = ($urandom_range(0, 15) == 0) ? $urandom_range(32, 4095)
                                                    : $urandom_range(0, 31);
      q.push_back(mk(h, k, idx, {$urandom, $urandom}, 1'b0));
    end
    if ($urandom_range(0, 3) != 0)
      for (int h = 0; h < NH; h++) q.push_back(mk(h, 3, 0, {$urandom, $urandom}, 1'b0));
    q[q.size() - 1].last = 1'b1;
    if ($urandom_range(0, 7) == 0) hold_at = $urandom_range(0, q.size() - 1);
    run_seq($sformatf("rand%0d", s), q, hold_at);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " ready"}, 64'(bus.rec_ready), 64'(0));
    chk({tag, " wr_valid"}, 64'(bus.wr_valid), 64'(0));
    chk({tag, " reset_n"}, 64'(hart_reset_n), 64'((1 << NH) - 1));
    chk({tag, " done"}, 64'(done), 64'(0));
    chk({tag, " error"}, 64'(error), 64'(0));
    chk({tag, " err_code"}, 64'(err_code), 64'(0));
    chk({tag, " rec_count"}, 64'(rec_count), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t q[$];
    int guard;
    bus.rec_valid = 1'b0;
    bus.rec_hart  = '0;
    bus.rec_kind  = KindXpr;
    bus.rec_idx   = '0;
    bus.rec_data  = '0;
    bus.rec_last  = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("in reset");
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("after reset");

    q = {mk(0, 0, 5, 64'hDEAD, 0), mk(0, 3, 0, 64'h8000_0000, 0),
         mk(1, 3, 0, 64'h8000_1000, 0), mk(2, 3, 0, 64'h8000_2000, 1)};
    run_seq("main", q, -1);
    q = {mk(1, 0, 0, 64'h1234, 0), mk(0, 3, 0, 64'h10, 0),
         mk(1, 3, 0, 64'h20, 0), mk(2, 3, 0, 64'h30, 1)};
    run_seq("x0", q, -1);
    q = {mk(0, 3, 0, 64'h8000_0000, 1)};
    run_seq("missing pc", q, -1);
    q = {mk(1, 1, 3, 64'hF00D, 0), mk(0, 3, 0, 64'h0, 1)};
    run_seq("ack timeout", q, 0);
    q = {mk(3, 0, 1, 64'h1, 1)};
    run_seq("bad hart", q, -1);
    q = {mk(0, 1, 32, 64'h2, 1)};
    run_seq("bad idx", q, -1);

    // Start while accepting records aborts with err 5.
    pulse_start();
    @(negedge clock);
    chk("busy ready", 64'(bus.rec_ready), 64'(1));
    pulse_start();
    chk("busy error", 64'(error), 64'(1));
    chk("busy err_code", 64'(err_code), 64'(5));
    chk("busy reset_n", 64'(hart_reset_n), 64'(0));

    // Reset asserted while a write is outstanding.
    model('{mk(2, 2, 12'h300, 64'hAA, 0), mk(1, 0, 7, 64'hBB, 0)}, 1, guard, guard, guard);
    pulse_start();
    drive_rec(mk(2, 2, 12'h300, 64'hAA, 0), 1'b0);
    drive_rec(mk(1, 0, 7, 64'hBB, 0), 1'b1);
    repeat (3) @(negedge clock);
    chk("pre-reset wr_valid", 64'(bus.wr_valid), 64'(2));
    chk("pre-reset rec_count", 64'(rec_count), 64'(1));
    reset = 1'b0;
    #1;
    check_reset_values("mid-write reset");
    @(negedge clock);
    reset = 1'b1;
    withhold = 1'b0;
    chk("reset scoreboard empty", 64'(exp_q.size()), 64'(0));

    for (int s = 0; s < 10; s++) rand_seq(s);
    q = {mk(2, 3, 0, 64'h1, 0), mk(0, 2, 12'hFFF, 64'h2, 0), mk(1, 3, 0, 64'h3, 0),
         mk(0, 3, 0, 64'h4, 1)};
    run_seq("final", q, -1);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
